// File: rtl/mmio_pkg.sv
// Shared types and default address map for the MMIO read controller.
package mmio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } mmio_state_e;

   localparam int unsigned ERR_CNT_W = 8;

   localparam logic [31:0] MMIO_RAM_BASE  = 32'h0000_1000;
   localparam logic [31:0] MMIO_RAM_MASK  = 32'h0000_F000;
   localparam logic [31:0] MMIO_SW_BASE   = 32'h0000_2010;
   localparam logic [31:0] MMIO_SW_MASK   = 32'h0000_F0F0;
   localparam logic [31:0] MMIO_UART_BASE = 32'h0000_2008;
   localparam logic [31:0] MMIO_UART_MASK = 32'h0000_F00F;
   localparam logic [31:0] MMIO_TMR_BASE  = 32'h0000_2030;
   localparam logic [31:0] MMIO_TMR_MASK  = 32'h0000_F0F0;

   // Width of a slave index; a single-slave map still gets a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational base/mask region decoder; the lowest matching index wins.
module mmio_addr_match
   import mmio_pkg::*;
#(
   parameter int unsigned N_SLAVES = 4,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic [ADDR_W-1:0]                  addr,
   input  logic [N_SLAVES*ADDR_W-1:0]         slave_base,
   input  logic [N_SLAVES*ADDR_W-1:0]         slave_mask,
   output logic                               hit_c,
   output logic [idx_width(N_SLAVES)-1:0]     index_c
);

   localparam int unsigned IDX_W = idx_width(N_SLAVES);

   // Scan from the top so that a lower hitting index overrides a higher one.
   always_comb begin
      hit_c   = 1'b0;
      index_c = '0;
      for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
         if ((addr & slave_mask[i*ADDR_W +: ADDR_W]) ==
             (slave_base[i*ADDR_W +: ADDR_W] & slave_mask[i*ADDR_W +: ADDR_W])) begin
            hit_c   = 1'b1;
            index_c = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mmio_read_ctrl.sv
// Load-path read controller: decodes the address, strobes one slave, waits
// for its ack (bounded by TIMEOUT) and returns registered data with status.
module mmio_read_ctrl
   import mmio_pkg::*;
#(
   parameter int unsigned N_SLAVES = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
      {MMIO_TMR_BASE, MMIO_UART_BASE, MMIO_SW_BASE, MMIO_RAM_BASE},
   parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK =
      {MMIO_TMR_MASK, MMIO_UART_MASK, MMIO_SW_MASK, MMIO_RAM_MASK}
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            rd_req_i,
   input  logic [ADDR_W-1:0]               Data_Address_i,
   output logic                            busy_o,
   output logic [N_SLAVES-1:0]             slave_re_o,
   input  logic [N_SLAVES-1:0]             slave_ack_i,
   input  logic [N_SLAVES*DATA_W-1:0]      slave_rdata_i,
   output logic [DATA_W-1:0]               rd_data_o,
   output logic                            rd_valid_o,
   output logic                            rd_err_o,
   output logic [idx_width(N_SLAVES)-1:0]  sel_o,
   output logic [ERR_CNT_W-1:0]            err_count_o
);

   localparam int unsigned IDX_W = idx_width(N_SLAVES);
   localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

   mmio_state_e        state;
   logic [TMR_W-1:0]   timer;
   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic               ack_sel;
   logic [DATA_W-1:0]  rdata_sel;

   mmio_addr_match #(
      .N_SLAVES (N_SLAVES),
      .ADDR_W   (ADDR_W)
   ) u_match (
      .addr       (Data_Address_i),
      .slave_base (SLAVE_BASE),
      .slave_mask (SLAVE_MASK),
      .hit_c      (dec_hit),
      .index_c    (dec_idx)
   );

   // Only the latched slave's ack and data are visible to the FSM.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         if (sel_o == IDX_W'(i)) begin
            ack_sel   = slave_ack_i[i];
            rdata_sel = slave_rdata_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         timer       <= '0;
         busy_o      <= 1'b0;
         slave_re_o  <= '0;
         rd_data_o   <= '0;
         rd_valid_o  <= 1'b0;
         rd_err_o    <= 1'b0;
         sel_o       <= '0;
         err_count_o <= '0;
      end else begin
         slave_re_o <= '0;
         rd_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_req_i) begin
                  sel_o  <= dec_idx;
                  busy_o <= 1'b1;
                  if (dec_hit) begin
                     state               <= STROBE;
                     timer               <= '0;
                     slave_re_o[dec_idx] <= 1'b1;
                  end else begin
                     state      <= RESP;
                     rd_valid_o <= 1'b1;
                     rd_err_o   <= 1'b1;
                     rd_data_o  <= '0;
                     if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
                  end
               end
            end
            STROBE, WAIT: begin
               // An ack in the final timeout cycle still completes cleanly.
               if (ack_sel) begin
                  state      <= RESP;
                  rd_valid_o <= 1'b1;
                  rd_err_o   <= 1'b0;
                  rd_data_o  <= rdata_sel;
               end else if (state == WAIT && timer == TMR_W'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  rd_valid_o <= 1'b1;
                  rd_err_o   <= 1'b1;
                  rd_data_o  <= '0;
                  if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
               end else begin
                  state <= WAIT;
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_read_ctrl.sv
// Self-checking bench for mmio_read_ctrl with a transaction-level reference model.
module tb_mmio_read_ctrl;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            rd_req;
   logic [AW-1:0]   addr;
   logic            busy;
   logic [N-1:0]    re;
   logic [N-1:0]    ack;
   logic [N*DW-1:0] rdata;
   logic [DW-1:0]   rd_data;
   logic            rd_valid;
   logic            rd_err;
   logic [1:0]      sel;
   logic [7:0]      err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt     = 0;

   // Observations from the last transaction.
   logic [N-1:0]  obs_re;
   int            obs_re_cycles;
   int            obs_re_cyc;
   int            obs_valid_cyc;
   logic [DW-1:0] obs_data;
   logic          obs_err;
   logic [1:0]    obs_sel;
   logic [7:0]    obs_cnt;
   logic          obs_busy_ok;
   logic          obs_idle_after;

   mmio_read_ctrl #(
      .N_SLAVES (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .TIMEOUT  (TO)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .rd_req_i       (rd_req),
      .Data_Address_i (addr),
      .busy_o         (busy),
      .slave_re_o     (re),
      .slave_ack_i    (ack),
      .slave_rdata_i  (rdata),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .rd_err_o       (rd_err),
      .sel_o          (sel),
      .err_count_o    (err_count)
   );

   always #5 clk = ~clk;

   // Default region map; returns the winning slave or -1 when unmapped.
   function automatic int exp_slave(input logic [31:0] a);
      logic [31:0] b, m;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       begin b = 32'h1000; m = 32'hF000; end
            1:       begin b = 32'h2010; m = 32'hF0F0; end
            2:       begin b = 32'h2008; m = 32'hF00F; end
            default: begin b = 32'h2030; m = 32'hF0F0; end
         endcase
         if ((a & m) == (b & m)) return i;
      end
      return -1;
   endfunction

   function automatic void bump_cnt();
      if (cnt < 255) cnt = cnt + 1;
   endfunction

   // Issue one read; slave idx acks k cycles after the strobe cycle (k<0: never).
   task automatic do_read(input logic [31:0] a, input int k, input int idx,
                          input logic [31:0] d, input bit spur);
      obs_re = '0; obs_re_cycles = 0; obs_re_cyc = 0; obs_valid_cyc = 0;
      obs_data = '0; obs_err = 1'b0; obs_sel = '0; obs_cnt = '0; obs_busy_ok = 1'b1;
      @(negedge clk);
      rd_req = 1'b1; addr = a; ack = '0;
      @(negedge clk);
      rd_req = 1'b0; addr = $urandom;
      for (int c = 1; c <= 60; c++) begin
         ack = '0;
         if (re != '0) begin obs_re |= re; obs_re_cycles++; obs_re_cyc = c; end
         if (!busy) obs_busy_ok = 1'b0;
         if (rd_valid) begin
            obs_valid_cyc = c; obs_data = rd_data; obs_err = rd_err;
            obs_sel = sel; obs_cnt = err_count;
            break;
         end
         rdata = {$urandom, $urandom, $urandom, $urandom};
         if (k >= 0 && c == 1 + k) begin
            ack[idx] = 1'b1;
            rdata[idx*DW +: DW] = d;
         end else if (spur && idx >= 0 && c >= 2) begin
            ack[(idx + 1) % N] = 1'b1;
         end
         @(negedge clk);
      end
      ack = '0;
      @(negedge clk);
      obs_idle_after = !busy && !rd_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_req = 1'b0; addr = '0; ack = '0; rdata = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy, re, rd_valid, rd_err, sel} !== '0) begin
         n_fail++; $display("FAIL reset_ctrl: got %0h want 0", {busy, re, rd_valid, rd_err, sel});
      end
      n_tests++;
      if ({rd_data, err_count} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %0h want 0", {rd_data, err_count});
      end
      rst = 1'b0;
      cnt = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_read(32'h0000_1004, 0, 0, 32'hCAFE_0001, 1'b0);
      n_tests++;
      if (obs_re !== 4'b0001 || obs_re_cycles != 1 || obs_re_cyc != 1) begin
         n_fail++; $display("FAIL basic_strobe: got %b x%0d @%0d want 0001 x1 @1", obs_re, obs_re_cycles, obs_re_cyc);
      end
      n_tests++;
      if (obs_valid_cyc != 2) begin
         n_fail++; $display("FAIL basic_latency: got %0d want 2", obs_valid_cyc);
      end
      n_tests++;
      if (obs_data !== 32'hCAFE_0001 || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL basic_data: got %h err %b want cafe0001 err 0", obs_data, obs_err);
      end
      n_tests++;
      if (!obs_busy_ok || !obs_idle_after) begin
         n_fail++; $display("FAIL basic_busy: got busy_ok %b idle_after %b want 1 1", obs_busy_ok, obs_idle_after);
      end
   endtask

   task automatic test_priority();
      do_read(32'h0000_2018, 1, 1, 32'h1111_2222, 1'b0);
      n_tests++;
      if (obs_sel !== 2'd1 || obs_re !== 4'b0010 || obs_data !== 32'h1111_2222) begin
         n_fail++; $display("FAIL prio_2018: got sel %0d re %b data %h want 1 0010 11112222", obs_sel, obs_re, obs_data);
      end
      do_read(32'h0000_2038, 1, 2, 32'h3333_4444, 1'b0);
      n_tests++;
      if (obs_sel !== 2'd2 || obs_re !== 4'b0100 || obs_data !== 32'h3333_4444) begin
         n_fail++; $display("FAIL prio_2038: got sel %0d re %b data %h want 2 0100 33334444", obs_sel, obs_re, obs_data);
      end
   endtask

   task automatic test_wait_states();
      do_read(32'h0000_2034, 5, 3, 32'h0000_00AB, 1'b1);
      n_tests++;
      if (obs_valid_cyc != 7 || obs_re !== 4'b1000) begin
         n_fail++; $display("FAIL wait_latency: got %0d re %b want 7 1000", obs_valid_cyc, obs_re);
      end
      n_tests++;
      if (obs_data !== 32'h0000_00AB || obs_err !== 1'b0) begin
         n_fail++; $display("FAIL wait_data: got %h err %b want 000000ab err 0", obs_data, obs_err);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (rd_data !== 32'h0000_00AB || rd_err !== 1'b0 || rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL wait_hold: got %h err %b valid %b want 000000ab 0 0", rd_data, rd_err, rd_valid);
      end
   endtask

   task automatic test_unmapped();
      do_read(32'h0000_3000, -1, -1, '0, 1'b0);
      bump_cnt();
      n_tests++;
      if (obs_valid_cyc != 1 || obs_re_cycles != 0) begin
         n_fail++; $display("FAIL unmapped_timing: got valid @%0d strobes %0d want @1 0", obs_valid_cyc, obs_re_cycles);
      end
      n_tests++;
      if (obs_err !== 1'b1 || obs_data !== '0 || obs_cnt !== 8'(cnt)) begin
         n_fail++; $display("FAIL unmapped_err: got err %b data %h cnt %0d want 1 0 %0d", obs_err, obs_data, obs_cnt, cnt);
      end
   endtask

   task automatic test_timeout();
      do_read(32'h0000_1008, -1, 0, '0, 1'b0);
      bump_cnt();
      n_tests++;
      if (obs_valid_cyc != TO + 1 || obs_err !== 1'b1 || obs_data !== '0 || obs_cnt !== 8'(cnt)) begin
         n_fail++; $display("FAIL timeout: got @%0d err %b data %h cnt %0d want @%0d 1 0 %0d",
                            obs_valid_cyc, obs_err, obs_data, obs_cnt, TO + 1, cnt);
      end
      do_read(32'h0000_1008, TO - 1, 0, 32'h1234_5678, 1'b0);
      n_tests++;
      if (obs_valid_cyc != TO + 1 || obs_err !== 1'b0 || obs_data !== 32'h1234_5678 || obs_cnt !== 8'(cnt)) begin
         n_fail++; $display("FAIL timeout_ack_wins: got @%0d err %b data %h cnt %0d want @%0d 0 12345678 %0d",
                            obs_valid_cyc, obs_err, obs_data, obs_cnt, TO + 1, cnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      int idx, k, exp_v;
      logic exp_e;
      logic [31:0] exp_d;
      for (int it = 0; it < 40; it++) begin
         a = $urandom;
         a[15:12] = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a[7:4] = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'h3;
         if ($urandom_range(0, 1) == 1) a[3:0] = 4'h8;
         d = $urandom;
         k = $urandom_range(0, TO + 2);
         idx = exp_slave(a);
         if (idx < 0) begin
            exp_v = 1; exp_e = 1'b1; exp_d = '0;
         end else if (k <= TO - 1) begin
            exp_v = 2 + k; exp_e = 1'b0; exp_d = d;
         end else begin
            exp_v = TO + 1; exp_e = 1'b1; exp_d = '0;
         end
         if (exp_e) bump_cnt();
         do_read(a, (k <= TO - 1) ? k : -1, idx, d, $urandom_range(0, 1) == 1);
         n_tests++;
         if (obs_valid_cyc != exp_v || obs_err !== exp_e || obs_data !== exp_d || obs_cnt !== 8'(cnt)) begin
            n_fail++; $display("FAIL rand_resp a=%h: got @%0d err %b data %h cnt %0d want @%0d %b %h %0d",
                               a, obs_valid_cyc, obs_err, obs_data, obs_cnt, exp_v, exp_e, exp_d, cnt);
         end
         n_tests++;
         if (idx < 0) begin
            if (obs_re_cycles != 0) begin
               n_fail++; $display("FAIL rand_strobe a=%h: got %0d strobes want 0", a, obs_re_cycles);
            end
         end else if (obs_re !== 4'(1 << idx) || obs_re_cycles != 1 || obs_sel !== 2'(idx)) begin
            n_fail++; $display("FAIL rand_strobe a=%h: got re %b x%0d sel %0d want %b x1 sel %0d",
                               a, obs_re, obs_re_cycles, obs_sel, 4'(1 << idx), idx);
         end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 300; i++) begin
         do_read(32'h0000_3000 | 32'($urandom_range(0, 255)), -1, -1, '0, 1'b0);
         bump_cnt();
      end
      n_tests++;
      if (err_count !== 8'd255 || obs_cnt !== 8'd255) begin
         n_fail++; $display("FAIL saturate: got %0d (at valid %0d) want 255", err_count, obs_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic saw_valid;
      do_read(32'h0000_2010, 3, 1, 32'hA5A5_5A5A, 1'b0);
      @(negedge clk);
      rd_req = 1'b1; addr = 32'h0000_2030;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || sel !== 2'd3) begin
         n_fail++; $display("FAIL mid_pre: got busy %b sel %0d want 1 3", busy, sel);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({busy, re, rd_valid, rd_err, sel} !== '0 || {rd_data, err_count} !== '0) begin
         n_fail++; $display("FAIL mid_reset: got ctrl %0h data %h cnt %0d want 0", {busy, re, rd_valid, rd_err, sel}, rd_data, err_count);
      end
      cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      repeat (4) begin @(negedge clk); if (rd_valid || busy) saw_valid = 1'b1; end
      n_tests++;
      if (saw_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_no_valid: got activity %b want 0", saw_valid);
      end
      do_read(32'h0000_1ABC, 2, 0, 32'h0BAD_F00D, 1'b0);
      n_tests++;
      if (obs_valid_cyc != 4 || obs_err !== 1'b0 || obs_data !== 32'h0BAD_F00D || obs_cnt !== 8'd0) begin
         n_fail++; $display("FAIL mid_after: got @%0d err %b data %h cnt %0d want @4 0 0badf00d 0",
                            obs_valid_cyc, obs_err, obs_data, obs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_wait_states();
      test_unmapped();
      test_timeout();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_read_ctrl.md
# mmio_read_ctrl

Parametrised memory-mapped read controller between the single-cycle RISC-V core's load path and its peripherals (RAM, switches, UART, timer).
- Decodes the load address against a table of base/mask regions, with the lowest index winning.
- Strobes exactly one slave and waits for its acknowledge, up to a timeout.
- Returns registered read data with a valid/error pulse.
- Replaces fixed 2-bit select decoding with N regions, wait-state support, unmapped/timeout error reporting and an error counter.

## Interface
Parameters:
- N_SLAVES, 4, number of decoded regions (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles from strobe to ack before error (≥2)
- SLAVE_BASE, {0x2030, 0x2008, 0x2010, 0x1000} (index 3..0), packed N_SLAVES×ADDR_W region bases
- SLAVE_MASK, {0xF0F0, 0xF00F, 0xF0F0, 0xF000} (index 3..0), packed N_SLAVES×ADDR_W compare masks

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, asynchronous, active-high
- rd_req_i  in  1  core read request; sampled only in IDLE
- Data_Address_i  in  ADDR_W  read address; sampled with rd_req_i
- busy_o  out  1  transaction outstanding; core stalls while high
- slave_re_o  out  N_SLAVES  one-hot read strobe to the selected slave
- slave_ack_i  in  N_SLAVES  per-slave acknowledge
- slave_rdata_i  in  N_SLAVES×DATA_W  per-slave read data; valid with its ack
- rd_data_o  out  DATA_W  returned read data
- rd_valid_o  out  1  one-cycle completion pulse
- rd_err_o  out  1  completion was unmapped or timed out; qualified by rd_valid_o
- sel_o  out  $clog2(N_SLAVES) (min 1)  latched slave index, for debug
- err_count_o  out  8  saturating error count

## Operation
- Match rule: region i hits when (addr & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i]). The lowest hitting index wins. No hit means unmapped.
- FSM states and transitions:
  - IDLE: on rd_req_i, latch the address, decoded index and hit flag. On hit go to STROBE; otherwise go to RESP with error.
  - STROBE: slave_re_o[sel] = 1 for exactly this cycle; timer cleared to 0.
  - WAIT: strobe low; timer increments each cycle without ack.
  - RESP: rd_valid_o = 1 for one cycle, then back to IDLE.
- Ack handling:
  - Only slave_ack_i[sel] counts; acks from other slaves are ignored.
  - An ack is accepted in STROBE or WAIT. On acceptance, slave_rdata_i[sel] is captured into rd_data_o and the FSM goes to RESP with rd_err_o = 0.
- Timeout: if no ack by the time the timer reaches TIMEOUT-1 in WAIT, go to RESP with rd_err_o = 1 and rd_data_o = 0.
  - An ack arriving in the same cycle as the timeout wins; no error is flagged.
- Unmapped read: rd_data_o = 0 and rd_err_o = 1. No strobe is issued.
- busy_o = 1 in STROBE, WAIT and RESP. rd_req_i is ignored outside IDLE.
- rd_data_o and rd_err_o hold their values after RESP until the next completion.
- err_count_o increments on each completion with an error and saturates at 255.

## Timing
- Reset values: all outputs are 0; state = IDLE; timer = 0.
- Reset mid-transaction aborts immediately: no valid pulse, and the error counter is cleared.
- Zero-wait slave: request sampled at edge 0, STROBE in cycle 1 with ack in cycle 1, rd_valid_o in cycle 2. Latency is 2 cycles.
- k-wait slave (ack k cycles after the strobe cycle): rd_valid_o in cycle 2+k, provided k ≤ TIMEOUT-1.
- Timeout completion: rd_valid_o in cycle TIMEOUT+1.
- Unmapped completion: rd_valid_o in cycle 1.
- Back-to-back requests: the next request is accepted on the first IDLE cycle after RESP.

## Structure
- Package mmio_pkg holds:
  - the state enum (IDLE, STROBE, WAIT, RESP);
  - default map constants MMIO_RAM_BASE/MASK, MMIO_SW_BASE/MASK, MMIO_UART_BASE/MASK, MMIO_TMR_BASE/MASK;
  - ERR_CNT_W = 8.
- Sub-module mmio_addr_match (combinational): inputs address, SLAVE_BASE, SLAVE_MASK; outputs hit and index, lowest index first. It is verified standalone.

## Test plan
- Defaults, read of 0x0000_1004 with slave 0 acking in the strobe cycle with 0xCAFE_0001: slave_re_o = 0001, rd_valid_o in cycle 2, rd_data_o = 0xCAFE_0001, rd_err_o = 0.
- Overlap priority: read 0x2018 (matches slave 1 and slave 2): sel_o = 1, slave_re_o = 0010. Read 0x2038: sel_o = 2, since slave 2 also matches 0x2X38 and wins over slave 3.
- Wait states: slave 3 acks 5 cycles after the strobe with 0x0000_00AB: valid in cycle 7. A spurious slave_ack_i[0] during the wait is ignored.
- Unmapped 0x0000_3000: no strobe; valid in cycle 1 with rd_err_o = 1, rd_data_o = 0; err_count_o goes 0→1.
- Timeout (TIMEOUT = 16), no ack: valid in cycle 17 with error. Ack on cycle 16: no error. 300 unmapped reads: err_count_o = 255.
- rst_i asserted during WAIT: all outputs 0 immediately, FSM in IDLE. A new request after release completes normally.
